// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Memory request/response, redirect and decode-side signals of the fetch unit.
interface fetch_prefetch_unit_if #(
   parameter int unsigned DEPTH = 4
);
   import fetch_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             imem_req_valid;
   logic [XLEN-1:0]  imem_req_addr;
   logic             imem_req_ready;
   logic             imem_rsp_valid;
   logic [XLEN-1:0]  imem_rsp_data;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             id_ready;
   logic             fetch_valid;
   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  fetch_instr;
   logic [CNT_W-1:0] inflight;

   modport master (
      output imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr, inflight,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr, inflight,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             id_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two synchronous FIFO with flush; a push into a full FIFO is taken only
// together with a pop.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_c,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty_c,
   output logic                     full_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_c = (count_q == '0);
   assign full_c  = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty_c && !flush;
   assign do_push = push && (!full_c || do_pop) && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head_c = mem_q[rd_ptr_q];
   assign count  = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Credit-based instruction prefetcher feeding the IF/ID register; redirects flush
// the buffer and drain responses still owed by the memory.
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   fetch_prefetch_unit_if.master bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  next_pc_q, next_pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             req_valid_q, req_valid_d;
   logic [CNT_W-1:0] data_count_d;

   logic             redirect;
   logic             req_fire;
   logic             rsp_fire;
   logic             discard;
   logic             data_push;
   logic             data_pop;

   logic [XLEN-1:0]  rsp_pc;
   logic [CNT_W-1:0] addr_count;
   logic             addr_empty;
   logic             addr_full;
   logic [ENTRY_W-1:0] data_head;
   logic [CNT_W-1:0] data_count;
   logic             data_empty;
   logic             data_full;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;

   assign redirect  = bus.redirect_valid;
   assign req_fire  = req_valid_q && bus.imem_req_ready;
   // A response with nothing outstanding is a protocol error and is dropped here.
   assign rsp_fire  = bus.imem_rsp_valid && !addr_empty;
   assign discard   = redirect || (state_q == DRAIN);
   assign data_push = rsp_fire && !discard;
   assign data_pop  = !data_empty && bus.id_ready && !redirect;

   assign push_entry.pc    = rsp_pc;
   assign push_entry.instr = bus.imem_rsp_data;
   assign head_entry       = fetch_entry_t'(data_head);

   // Addresses of accepted requests, consumed in order by responses (kept or dropped).
   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN)
   ) u_addr_q (
      .clk       (clk),
      .rst_n     (reset),
      .push      (req_fire),
      .push_data (next_pc_q),
      .pop       (rsp_fire),
      .flush     (1'b0),
      .head_c    (rsp_pc),
      .count     (addr_count),
      .empty_c   (addr_empty),
      .full_c    (addr_full)
   );

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_data_q (
      .clk       (clk),
      .rst_n     (reset),
      .push      (data_push),
      .push_data (push_entry),
      .pop       (data_pop),
      .flush     (redirect),
      .head_c    (data_head),
      .count     (data_count),
      .empty_c   (data_empty),
      .full_c    (data_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= BOOT;
         next_pc_q   <= RESET_PC;
         inflight_q  <= '0;
         drop_cnt_q  <= '0;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         next_pc_q   <= next_pc_d;
         inflight_q  <= inflight_d;
         drop_cnt_q  <= drop_cnt_d;
         req_valid_q <= req_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      next_pc_d    = next_pc_q;
      drop_cnt_d   = drop_cnt_q;
      inflight_d   = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      data_count_d = data_count + CNT_W'(data_push) - CNT_W'(data_pop);

      if (req_fire) begin
         next_pc_d = next_pc_q + PC_STEP;
      end
      if ((drop_cnt_q != '0) && rsp_fire) begin
         drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end

      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
         default: state_d = BOOT;
      endcase

      // Redirect overrides everything; requests still owed (including one firing now) get dropped.
      if (redirect) begin
         next_pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
         drop_cnt_d   = inflight_d;
         data_count_d = '0;
         state_d      = (inflight_d != '0) ? DRAIN : RUN;
      end

      req_valid_d = (state_d != BOOT) &&
                    ((SUM_W'(inflight_d) + SUM_W'(data_count_d)) < SUM_W'(DEPTH));
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = next_pc_q;
   assign bus.fetch_valid    = !data_empty;
   assign bus.fetch_pc       = head_entry.pc;
   assign bus.fetch_instr    = head_entry.instr;
   assign bus.inflight       = inflight_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_without_request: assert (!(bus.imem_rsp_valid && (inflight_q == '0)));
         addr_queue_overflow: assert (!(req_fire && addr_full));
         data_queue_overflow: assert (!(data_push && data_full && !data_pop));
         addr_queue_tracks:   assert (addr_count == inflight_q);
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised scoreboard bench for fetch_prefetch_unit against a latency-modelled memory.
module tb_fetch_prefetch_unit;
   import fetch_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fetch_prefetch_unit_if #(.DEPTH(DEPTH)) bus ();

   fetch_prefetch_unit #(
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct { logic [31:0] addr; int due; } pend_t;

   exp_t        exp_q[$];
   pend_t       pend_q[$];
   logic [31:0] exp_tail;
   int total = 0;
   int bad = 0;
   int delivered = 0;
   int cyc = 0;
   int last_due = 0;
   int lat_min = 1;
   int lat_max = 1;
   int ready_pct = 100;
   int mdl_inflight = 0;
   int mdl_inflight_nx = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected delivery stream: sequential words from the latest start address.
   function automatic void top_up();
      exp_t e;
      while (exp_q.size() < 16) begin
         e.pc    = exp_tail;
         e.instr = mem_word(exp_tail);
         exp_q.push_back(e);
         exp_tail = exp_tail + 32'd4;
      end
   endfunction

   function automatic void restart_stream(input logic [31:0] start);
      exp_q.delete();
      exp_tail = start & 32'hFFFF_FFFC;
      top_up();
   endfunction

   task automatic step();
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      top_up();
   endtask

   task automatic do_redirect(input logic [31:0] tgt);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = tgt;
      restart_stream(tgt);
   endtask

   task automatic wait_req(input string name, input logic [31:0] addr);
      int n = 0;
      do begin step(); n++; end while (!bus.imem_req_valid && n < 30);
      check({name, "_seen"}, 32'(bus.imem_req_valid), 32'd1);
      check(name, bus.imem_req_addr, addr);
   endtask

   task automatic wait_fetch(input string name, input logic [31:0] pc);
      int n = 0;
      do begin step(); n++; end while (!bus.fetch_valid && n < 30);
      check({name, "_seen"}, 32'(bus.fetch_valid), 32'd1);
      check({name, "_pc"}, bus.fetch_pc, pc);
      check({name, "_instr"}, bus.fetch_instr, mem_word(pc));
   endtask

   // Memory: in-order responses after a random latency, random request acceptance.
   initial begin : memory
      pend_t p;
      logic  rsp;
      logic  rdy;
      logic  fire;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         mdl_inflight = mdl_inflight_nx;
         if (!reset) begin
            pend_q.delete();
            mdl_inflight       = 0;
            mdl_inflight_nx    = 0;
            last_due           = cyc;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_req_ready = 1'b0;
         end else begin
            rsp = 1'b0;
            bus.imem_rsp_data = $urandom;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
               rsp = 1'b1;
               bus.imem_rsp_data = mem_word(pend_q[0].addr);
               void'(pend_q.pop_front());
            end
            bus.imem_rsp_valid = rsp;
            rdy  = ($urandom_range(99) < ready_pct);
            bus.imem_req_ready = rdy;
            fire = bus.imem_req_valid && rdy;
            if (fire) begin
               check("req_align", 32'(bus.imem_req_addr[1:0]), 32'd0);
               p.addr = bus.imem_req_addr;
               p.due  = cyc + int'($urandom_range(lat_max, lat_min));
               if (p.due < last_due) p.due = last_due;
               last_due = p.due;
               pend_q.push_back(p);
            end
            mdl_inflight_nx = mdl_inflight + int'(fire) - int'(rsp);
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted instruction and checks protocol rules.
   initial begin : monitor
      exp_t        e;
      logic        hold_v;
      logic [31:0] hold_pc;
      logic        rq_v;
      logic [31:0] rq_addr;
      logic        redir_prev;
      hold_v = 1'b0; rq_v = 1'b0; redir_prev = 1'b0; hold_pc = '0; rq_addr = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            hold_v = 1'b0; rq_v = 1'b0; redir_prev = 1'b0;
            continue;
         end
         check("inflight_model", 32'(bus.inflight), 32'(mdl_inflight));
         if (redir_prev) check("valid_after_redirect", 32'(bus.fetch_valid), 32'd0);
         if (hold_v) begin
            check("hold_valid", 32'(bus.fetch_valid), 32'd1);
            check("hold_pc", bus.fetch_pc, hold_pc);
         end
         if (rq_v) begin
            check("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
            check("req_hold_addr", bus.imem_req_addr, rq_addr);
         end
         if (bus.fetch_valid && bus.id_ready && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL scoreboard_empty: got pc %h want no delivery", bus.fetch_pc);
            end else begin
               e = exp_q.pop_front();
               check("fetch_pc", bus.fetch_pc, e.pc);
               check("fetch_instr", bus.fetch_instr, e.instr);
               delivered++;
            end
         end
         hold_v     = bus.fetch_valid && !bus.id_ready && !bus.redirect_valid;
         hold_pc    = bus.fetch_pc;
         rq_v       = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
         rq_addr    = bus.imem_req_addr;
         redir_prev = bus.redirect_valid;
      end
   end

   initial begin : stimulus
      int n;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b1;
      restart_stream(RST_PC);

      // Zero-wait memory: first instruction three cycles after reset release, then one per cycle.
      repeat (3) step();
      check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_fetch_pc", bus.fetch_pc, 32'd0);
      check("rst_inflight", 32'(bus.inflight), 32'd0);
      step();
      reset = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         check("first_valid_timing", 32'(bus.fetch_valid), 32'(k == 3));
      end
      check("first_pc", bus.fetch_pc, RST_PC);
      repeat (20) begin
         step();
         check("stream_valid", 32'(bus.fetch_valid), 32'd1);
      end

      // Redirect while a request fires and a response returns in the same cycle.
      step();
      check("redir_busy_inflight", 32'(bus.inflight), 32'd1);
      do_redirect(32'h0000_0040);
      wait_req("redir_40_addr", 32'h0000_0040);
      wait_fetch("redir_40_fetch", 32'h0000_0040);
      repeat (5) step();

      // Decode stall: credit limit stops requests, head holds, nothing lost afterwards.
      bus.id_ready = 1'b0;
      repeat (10) step();
      check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("stall_inflight", 32'(bus.inflight), 32'd0);
      check("stall_fetch_valid", 32'(bus.fetch_valid), 32'd1);
      bus.id_ready = 1'b1;
      repeat (10) step();

      // Three-cycle memory: redirect with three requests outstanding.
      lat_min = 3; lat_max = 3;
      n = 0;
      do begin step(); n++; end while (bus.inflight != 3 && n < 40);
      check("three_inflight", 32'(bus.inflight), 32'd3);
      do_redirect(32'h0000_0100);
      wait_req("redir_100_addr", 32'h0000_0100);
      wait_fetch("redir_100_fetch", 32'h0000_0100);
      repeat (4) step();
      do_redirect(32'h0000_0103);
      wait_req("redir_103_addr", 32'h0000_0100);
      wait_fetch("redir_103_fetch", 32'h0000_0100);
      step();
      do_redirect(32'h0000_0300);
      step();
      do_redirect(32'h0000_0400);
      wait_fetch("back_to_back", 32'h0000_0400);
      step();
      do_redirect(32'hFFFF_FFF8);
      repeat (20) step();

      // Reset with a full buffer.
      lat_min = 1; lat_max = 1;
      bus.id_ready = 1'b0;
      n = 0;
      do begin step(); n++; end
         while (!(bus.fetch_valid && !bus.imem_req_valid && bus.inflight == 0) && n < 40);
      check("full_before_reset", 32'(bus.fetch_valid), 32'd1);
      step();
      reset = 1'b0;
      restart_stream(RST_PC);
      #1;
      check("midrst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      check("midrst_inflight", 32'(bus.inflight), 32'd0);
      check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("midrst_fetch_instr", bus.fetch_instr, 32'd0);
      step();
      reset = 1'b1;
      step();
      check("post_boot_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("post_boot_req_addr", bus.imem_req_addr, RST_PC);
      bus.id_ready = 1'b1;
      repeat (10) step();

      // Random traffic with random redirects and one reset.
      lat_min = 1; lat_max = 4; ready_pct = 70;
      for (int c = 0; c < 3000; c++) begin
         step();
         bus.id_ready = ($urandom_range(99) < 75);
         if (c == 1500) begin
            reset = 1'b0;
            restart_stream(RST_PC);
            step();
            reset = 1'b1;
         end else if ($urandom_range(24) == 0) begin
            do_redirect($urandom & 32'h0000_FFFF);
         end
      end
      bus.id_ready = 1'b1;
      repeat (20) step();
      check("delivered_enough", 32'(delivered > 300), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
